keypad_scan: RTL

4x4 matrix keypad scanner and debouncer feeding the clock's key-driven status/setting FSM. Drives the keypad columns one at a time, samples the rows, debounces across full scan frames and emits exactly one single-cycle `Value_en` strobe with a 4-bit `KEY_Value` per physical key press. Auto-repeat is not supported: holding a key produces no further strobes.

---
 rtl/keypad_scan_pkg.sv | 67 ++++++
 rtl/keypad_scan_sync.sv | 39 +++
 rtl/keypad_scan.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// ---------------------------------------------------------------------------
// keypad_scan_pkg
//
// Shared definitions for the 4x4 keypad scanner:
//   - key codes for the letter and symbol keys
//   - debounce FSM state encoding
//   - per-frame scan result encoding
//   - keyCode(): maps a (row, col) position on the matrix to its key code
// ---------------------------------------------------------------------------
package keypad_scan_pkg;

  // Codes for the non-digit keys; digits map to their own value.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Idle level of the row lines (pull-ups, nothing pressed).
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_t;

  // What one complete scan of all four columns saw.
  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_result_t;

  // Key code lookup for the physical layout:
  //   row 0: 1 2 3 A
  //   row 1: 4 5 6 B
  //   row 2: 7 8 9 C
  //   row 3: * 0 # D
  function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_sync.sv
// ---------------------------------------------------------------------------
// keypad_sync
//
// Two-flop synchronizer for the four keypad row lines, which arrive
// asynchronously from the switch matrix. Both stages reset to the idle
// (all-high) level so that no phantom key is seen straight after reset.
//
// Ports:
//   clk       system clock
//   rstn      synchronous active-low reset
//   i_rowsN   raw active-low row lines
//   o_rowsN   synchronized active-low row lines
// ---------------------------------------------------------------------------
module keypad_sync (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_rowsN,
  output logic [3:0] o_rowsN
);
  import keypad_scan_pkg::*;

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // First stage may go metastable; second stage gives it a full cycle to
  // resolve before anything downstream looks at it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= ROWS_IDLE;
      r_sync <= ROWS_IDLE;
    end else begin
      r_meta <= i_rowsN;
      r_sync <= r_meta;
    end
  end

  assign o_rowsN = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//
// 4x4 matrix keypad scanner and debouncer. Drives one column low at a time,
// samples the synchronized rows at the end of each column dwell, folds the
// four column samples of a frame into NONE / SINGLE(k) / MULTI, and runs a
// debounce FSM once per frame. One accepted press gives exactly one
// single-cycle Value_en strobe; holding a key does not repeat.
//
// Parameters:
//   SCAN_DIV        clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical frames to accept a press, empty frames to
//                   accept a release (>= 2)
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   row_n      keypad rows, active-low, asynchronous
//   col_n      column drive, active-low, one column at a time
//   KEY_Value  code of the last accepted key
//   Value_en   one-cycle strobe for a newly accepted key
//   key_held   high from acceptance until release is accepted
// ---------------------------------------------------------------------------
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] KEY_Value,
  output logic       Value_en,
  output logic       key_held
);
  import keypad_scan_pkg::*;

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [3:0]         w_rowSync;

  logic [DWELL_W-1:0] r_dwellCnt;
  logic [1:0]         r_colIdx;
  logic [3:0]         r_colN;
  logic               w_dwellEnd;
  logic               w_frameEnd;
  logic [1:0]         w_colNext;

  logic [1:0]         r_hitCnt;
  logic [3:0]         r_firstCode;
  logic [2:0]         w_colHits;
  logic [1:0]         w_colFirstRow;
  logic [1:0]         w_baseCnt;
  logic [3:0]         w_baseCode;
  logic [2:0]         w_hitSum;
  logic [1:0]         w_newCnt;
  logic [3:0]         w_newCode;
  frame_result_t      w_frameResult;

  scan_state_t        r_state;
  logic [3:0]         r_cand;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_rcnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [CNT_W-1:0]   w_rcntNext;
  logic [3:0]         r_keyValue;
  logic               r_valueEn;
  logic               r_keyHeld;

  // -------------------------------------------------------------------------
  // Row synchronizer
  // -------------------------------------------------------------------------
  keypad_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_rowsN (row_n),
    .o_rowsN (w_rowSync)
  );

  // -------------------------------------------------------------------------
  // Scan timing: the dwell counter runs 0..SCAN_DIV-1 per column. The last
  // dwell cycle is both the row sample point and the column step, which
  // leaves SCAN_DIV-3 cycles of settling after the two synchronizer stages.
  // -------------------------------------------------------------------------
  assign w_dwellEnd = (r_dwellCnt == DWELL_LAST);
  assign w_frameEnd = w_dwellEnd && (r_colIdx == 2'd3);
  assign w_colNext  = r_colIdx + 2'd1;

  // Column drive is rebuilt from the index each step so it can never lose
  // its single low bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dwellCnt <= '0;
      r_colIdx   <= 2'd0;
      r_colN     <= 4'b1110;
    end else if (w_dwellEnd) begin
      r_dwellCnt <= '0;
      r_colIdx   <= w_colNext;
      r_colN     <= ~(4'b0001 << w_colNext);
    end else begin
      r_dwellCnt <= r_dwellCnt + DWELL_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Frame accumulator: combines the current column sample with what the
  // earlier columns of this frame saw. Column 0 starts from empty, so the
  // stored values never leak between frames. The hit count saturates at 2
  // because only none/one/many matters.
  // -------------------------------------------------------------------------
  always_comb begin
    w_colHits     = 3'd0;
    w_colFirstRow = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!w_rowSync[r]) begin
        w_colHits     = w_colHits + 3'd1;
        w_colFirstRow = 2'(r);
      end
    end

    w_baseCnt  = (r_colIdx == 2'd0) ? 2'd0 : r_hitCnt;
    w_baseCode = (r_colIdx == 2'd0) ? 4'd0 : r_firstCode;
    w_hitSum   = {1'b0, w_baseCnt} + w_colHits;
    w_newCnt   = (w_hitSum >= 3'd2) ? 2'd2 : w_hitSum[1:0];

    if ((w_baseCnt == 2'd0) && (w_colHits != 3'd0)) begin
      w_newCode = keyCode(w_colFirstRow, r_colIdx);
    end else begin
      w_newCode = w_baseCode;
    end

    if (w_newCnt == 2'd0) begin
      w_frameResult = FRAME_NONE;
    end else if (w_newCnt == 2'd1) begin
      w_frameResult = FRAME_SINGLE;
    end else begin
      w_frameResult = FRAME_MULTI;
    end
  end

  // Capture the running frame totals at every column sample point.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hitCnt    <= 2'd0;
      r_firstCode <= 4'd0;
    end else if (w_dwellEnd) begin
      r_hitCnt    <= w_newCnt;
      r_firstCode <= w_newCode;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce FSM, stepped once per frame on the column-3 sample. Outputs are
  // registered here so Value_en, KEY_Value and key_held all change on the
  // cycle right after the deciding sample.
  // -------------------------------------------------------------------------
  assign w_cntNext  = r_cnt + CNT_W'(1);
  assign w_rcntNext = r_rcnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cand     <= 4'd0;
      r_cnt      <= '0;
      r_rcnt     <= '0;
      r_keyValue <= 4'd0;
      r_valueEn  <= 1'b0;
      r_keyHeld  <= 1'b0;
    end else begin
      r_valueEn <= 1'b0;
      if (w_frameEnd) begin
        case (r_state)
          ST_IDLE: begin
            if (w_frameResult == FRAME_SINGLE) begin
              r_cand  <= w_newCode;
              r_cnt   <= CNT_W'(1);
              r_state <= ST_DEBOUNCE;
            end
          end

          ST_DEBOUNCE: begin
            if (w_frameResult == FRAME_SINGLE) begin
              if (w_newCode == r_cand) begin
                if (w_cntNext == DEB_TARGET) begin
                  r_keyValue <= r_cand;
                  r_valueEn  <= 1'b1;
                  r_keyHeld  <= 1'b1;
                  r_cnt      <= '0;
                  r_rcnt     <= '0;
                  r_state    <= ST_HELD;
                end else begin
                  r_cnt <= w_cntNext;
                end
              end else begin
                r_cand <= w_newCode;
                r_cnt  <= CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end

          ST_HELD: begin
            // Any contact, including a multi-key jumble, restarts the
            // release count so a release is only taken from clean frames.
            if (w_frameResult == FRAME_NONE) begin
              if (w_rcntNext == DEB_TARGET) begin
                r_rcnt    <= '0;
                r_keyHeld <= 1'b0;
                r_state   <= ST_IDLE;
              end else begin
                r_rcnt <= w_rcntNext;
              end
            end else begin
              r_rcnt <= '0;
            end
          end

          default: begin
            r_cnt     <= '0;
            r_rcnt    <= '0;
            r_keyHeld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign col_n     = r_colN;
  assign KEY_Value = r_keyValue;
  assign Value_en  = r_valueEn;
  assign key_held  = r_keyHeld;

endmodule
